// File: rtl/shifter_pkg.sv
// Shared datapath definitions for the single-bit shifter: operation
// encoding and the default operand width.
package shifter_pkg;

  // Default datapath width in bits.
  localparam int DATA_W = 16;

  // Shift operation select.
  typedef enum logic [1:0] {
    SH_NONE = 2'b00,  // pass operand through unchanged
    SH_LSL  = 2'b01,  // logical shift left by one, LSB filled with 0
    SH_LSR  = 2'b10,  // logical shift right by one, MSB filled with 0
    SH_ASR  = 2'b11   // arithmetic shift right by one, MSB replicated
  } shift_op_e;

endpackage : shifter_pkg

// File: rtl/shifter_core.sv
// Purely combinational shift mux. Produces the shifted operand and the
// bit that falls off the end (carry). No clock, no state.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_e        op_i,
  output logic [WIDTH-1:0] sout_o,
  output logic             shout_o
);

  // Select the shifted value and the shifted-out bit for each operation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave a value unassigned and infer a latch.
    sout_o  = data_i;
    shout_o = 1'b0;
    case (op_i)
      SH_NONE: begin
        sout_o  = data_i;
        shout_o = 1'b0;
      end
      SH_LSL: begin
        sout_o  = {data_i[WIDTH-2:0], 1'b0};
        shout_o = data_i[WIDTH-1];
      end
      SH_LSR: begin
        sout_o  = {1'b0, data_i[WIDTH-1:1]};
        shout_o = data_i[0];
      end
      SH_ASR: begin
        sout_o  = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        shout_o = data_i[0];
      end
      default: begin
        // Only reachable with an unknown select: propagate X, do not mask it.
        sout_o  = 'x;
        shout_o = 1'bx;
      end
    endcase
  end

endmodule : shifter_core

// File: rtl/shifter.sv
// Single-bit shifter for the B operand path. The combinational result is
// available in the same cycle; an optional one-cycle registered copy with
// valid tracking, carry-out and zero flag serves pipelined consumers.
module shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sout,
  output logic [WIDTH-1:0] sout_q,
  output logic             out_valid,
  output logic             shout_q,
  output logic             zero_q
);

  // A one-bit operand has nothing to shift against.
  if (WIDTH < 2) begin : g_width_check
    $error("shifter: WIDTH must be at least 2");
  end

  logic             shout;
  logic [WIDTH-1:0] sout_d;
  logic             shout_d;
  logic             zero_d;
  logic             out_valid_d;
  logic             out_valid_q;

  shifter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data_i  (in),
    .op_i    (shift_op_e'(shift)),
    .sout_o  (sout),
    .shout_o (shout)
  );

  // Next-state: capture on a valid input, otherwise hold data and drop valid.
  always_comb begin
    sout_d      = sout_q;
    shout_d     = shout_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sout_d      = sout;
      shout_d     = shout;
      zero_d      = (sout == '0);
      out_valid_d = 1'b1;
    end
  end

  // Capture registers; synchronous reset overrides any capture on that edge.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      sout_q      <= '0;
      shout_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sout_q      <= sout_d;
      shout_q     <= shout_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule : shifter

// File: tb/tb_shifter.sv
// Directed and randomised checks for the shifter: combinational result,
// registered capture, flags, valid tracking and synchronous reset.
module tb_shifter;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] in;
  logic [1:0]   shift;
  logic         in_valid;
  logic [W-1:0] sout;
  logic [W-1:0] sout_q;
  logic         out_valid;
  logic         shout_q;
  logic         zero_q;

  int n_checks;
  int n_fails;

  shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .shift     (shift),
    .in_valid  (in_valid),
    .sout      (sout),
    .sout_q    (sout_q),
    .out_valid (out_valid),
    .shout_q   (shout_q),
    .zero_q    (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge and let combinational logic settle.
  task automatic drive(input logic rst, input logic [W-1:0] d,
                       input logic [1:0] op, input logic vld);
    @(negedge clk);
    reset    = rst;
    in       = d;
    shift    = op;
    in_valid = vld;
    #1;
  endtask

  // Advance past the next rising edge to sample registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 16'hFFFF, 2'b00, 1'b1);
    tick();
    n_checks++;
    if (sout_q !== 16'h0000) begin
      n_fails++;
      $display("FAIL reset_sout_q got=%h exp=%h", sout_q, 16'h0000);
    end
    n_checks++;
    if ({out_valid, shout_q, zero_q} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_flags got=%b exp=%b", {out_valid, shout_q, zero_q}, 3'b000);
    end
    n_checks++;
    if (sout !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL reset_comb_sout got=%h exp=%h", sout, 16'hFFFF);
    end
  endtask

  // in=0xF0CF through all four ops, checking comb result then the capture.
  task automatic test_ops_f0cf();
    logic [W-1:0] exp_s [4];
    logic         exp_c [4];
    exp_s[0] = 16'hF0CF; exp_c[0] = 1'b0;
    exp_s[1] = 16'hE19E; exp_c[1] = 1'b1;
    exp_s[2] = 16'h7867; exp_c[2] = 1'b1;
    exp_s[3] = 16'hF867; exp_c[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'hF0CF, 2'(i), 1'b1);
      n_checks++;
      if (sout !== exp_s[i]) begin
        n_fails++;
        $display("FAIL f0cf_sout op=%0d got=%h exp=%h", i, sout, exp_s[i]);
      end
      tick();
      n_checks++;
      if ({sout_q, shout_q, zero_q, out_valid} !== {exp_s[i], exp_c[i], 1'b0, 1'b1}) begin
        n_fails++;
        $display("FAIL f0cf_reg op=%0d got=%h/%b/%b/%b exp=%h/%b/0/1",
                 i, sout_q, shout_q, zero_q, out_valid, exp_s[i], exp_c[i]);
      end
    end
  endtask

  // 0x8000 shifted left: zero result with carry, then a hold cycle.
  task automatic test_lsl_zero();
    drive(1'b0, 16'h8000, 2'b01, 1'b1);
    n_checks++;
    if (sout !== 16'h0000) begin
      n_fails++;
      $display("FAIL lsl8000_sout got=%h exp=%h", sout, 16'h0000);
    end
    tick();
    n_checks++;
    if ({sout_q, zero_q, shout_q, out_valid} !== {16'h0000, 3'b111}) begin
      n_fails++;
      $display("FAIL lsl8000_reg got=%h/%b/%b/%b exp=0000/1/1/1",
               sout_q, zero_q, shout_q, out_valid);
    end
    drive(1'b0, 16'h1234, 2'b10, 1'b0);
    tick();
    n_checks++;
    if ({sout_q, zero_q, shout_q, out_valid} !== {16'h0000, 3'b110}) begin
      n_fails++;
      $display("FAIL hold_reg got=%h/%b/%b/%b exp=0000/1/1/0",
               sout_q, zero_q, shout_q, out_valid);
    end
  endtask

  // Sign and MSB boundary cases on the combinational output.
  task automatic test_boundaries();
    drive(1'b0, 16'hFFFF, 2'b11, 1'b0);
    n_checks++;
    if (sout !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL asr_ones got=%h exp=%h", sout, 16'hFFFF);
    end
    drive(1'b0, 16'h8000, 2'b10, 1'b0);
    n_checks++;
    if (sout !== 16'h4000) begin
      n_fails++;
      $display("FAIL lsr_msb got=%h exp=%h", sout, 16'h4000);
    end
    drive(1'b0, 16'h8000, 2'b11, 1'b0);
    n_checks++;
    if (sout !== 16'hC000) begin
      n_fails++;
      $display("FAIL asr_msb got=%h exp=%h", sout, 16'hC000);
    end
  endtask

  // 0x8001 with a different op every cycle; each result lands one cycle later.
  task automatic test_back_to_back();
    logic [W-1:0] exp_s [4];
    exp_s[0] = 16'h8001;
    exp_s[1] = 16'h0002;
    exp_s[2] = 16'h4000;
    exp_s[3] = 16'hC000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h8001, 2'(i), 1'b1);
      tick();
      n_checks++;
      if ({sout_q, shout_q, out_valid} !== {exp_s[i], (i != 0), 1'b1}) begin
        n_fails++;
        $display("FAIL b2b op=%0d got=%h/%b/%b exp=%h/%b/1",
                 i, sout_q, shout_q, out_valid, exp_s[i], (i != 0));
      end
    end
  endtask

  // Reset arriving on an edge with a valid input discards that capture.
  task automatic test_reset_mid();
    drive(1'b0, 16'h1234, 2'b00, 1'b1);
    tick();
    drive(1'b1, 16'hFFFF, 2'b00, 1'b1);
    n_checks++;
    if (sout !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL rstmid_comb_pre got=%h exp=%h", sout, 16'hFFFF);
    end
    tick();
    n_checks++;
    if ({sout_q, shout_q, zero_q, out_valid} !== {16'h0000, 3'b000}) begin
      n_fails++;
      $display("FAIL rstmid_reg got=%h/%b/%b/%b exp=0000/0/0/0",
               sout_q, shout_q, zero_q, out_valid);
    end
    n_checks++;
    if (sout !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL rstmid_comb_post got=%h exp=%h", sout, 16'hFFFF);
    end
    drive(1'b0, 16'hFFFF, 2'b00, 1'b0);
    tick();
    n_checks++;
    if ({sout_q, out_valid} !== {16'h0000, 1'b0}) begin
      n_fails++;
      $display("FAIL rstmid_after got=%h/%b exp=0000/0", sout_q, out_valid);
    end
  endtask

  // Random operands and ops against an arithmetic reference model.
  task automatic test_random();
    logic [W-1:0] d, exp_s, held_s;
    logic [1:0]   op;
    logic         vld, exp_c, held_c, held_z;
    held_s = sout_q;
    held_c = shout_q;
    held_z = zero_q;
    for (int n = 0; n < 1000; n++) begin
      d   = W'($urandom);
      op  = 2'($urandom_range(0, 3));
      vld = ($urandom_range(0, 3) != 0);
      case (op)
        2'd0:    begin exp_s = d;                    exp_c = 1'b0;   end
        2'd1:    begin exp_s = W'(d * 2);            exp_c = d[W-1]; end
        2'd2:    begin exp_s = d / 2;                exp_c = d[0];   end
        default: begin exp_s = W'($signed(d) >>> 1); exp_c = d[0];   end
      endcase
      drive(1'b0, d, op, vld);
      n_checks++;
      if (sout !== exp_s) begin
        n_fails++;
        $display("FAIL rand_sout n=%0d in=%h op=%0d got=%h exp=%h", n, d, op, sout, exp_s);
      end
      if (vld) begin
        held_s = exp_s;
        held_c = exp_c;
        held_z = (exp_s == '0);
      end
      tick();
      n_checks++;
      if ({sout_q, shout_q, zero_q, out_valid} !== {held_s, held_c, held_z, vld}) begin
        n_fails++;
        $display("FAIL rand_reg n=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b",
                 n, sout_q, shout_q, zero_q, out_valid, held_s, held_c, held_z, vld);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    in       = '0;
    shift    = 2'b00;
    in_valid = 1'b0;
    test_reset();
    test_ops_f0cf();
    test_lsl_zero();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_shifter
